// File: rtl/alu_seq_pkg.sv
// Shared op encodings, FSM state type and counter sizing for alu_op_sequencer.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  localparam int unsigned ARITH_LAT_DEF = 1;
  localparam int unsigned CNT_W_DEF     = $clog2(ARITH_LAT_DEF + 1);

  function automatic int unsigned cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_rsp_hold.sv
// Response register with valid/ready: loads on capture, holds until the consumer takes it.
module alu_rsp_hold #(
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic             load_carry,
  input  logic             load_err,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
      rsp_carry <= load_carry;
      rsp_err   <= load_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for the signed arithmetic unit: accept, issue, wait out latency, hold response.
// Optional macro ALU_DIV_ZERO_GUARD_EN short-circuits divide-by-zero straight to an error response.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned IN_W      = 4,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned ARITH_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IN_W-1:0]  cmd_a,
  input  logic [IN_W-1:0]  cmd_b,
  output logic [IN_W-1:0]  arith_a,
  output logic [IN_W-1:0]  arith_b,
  output logic             arith_enable,
  output logic [1:0]       alu_func_arith,
  input  logic [OUT_W-1:0] arith_out,
  input  logic             carry_out,
  input  logic             arith_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err
);

  localparam int unsigned CW = cnt_width(ARITH_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ARITH_LAT);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            guard_hit;
  logic            accept;
  logic            cap_unit;
  logic            cap_load;
  logic [OUT_W-1:0] cap_data;
  logic            cap_carry;
  logic            cap_err;

`ifdef ALU_DIV_ZERO_GUARD_EN
  assign guard_hit = (cmd_op == OP_DIV) && (cmd_b == '0);
`else
  assign guard_hit = 1'b0;
`endif

  assign accept   = (state == ST_IDLE) && cmd_valid;
  assign cap_unit = (state == ST_WAIT) && (cnt == CNT_ONE);

  // A guarded divide loads the hold register directly from IDLE with a fixed error response.
  always_comb begin
    cap_load  = cap_unit || (accept && guard_hit);
    cap_data  = '0;
    cap_carry = 1'b0;
    cap_err   = 1'b1;
    if (cap_unit) begin
      cap_data  = arith_out;
      cap_carry = carry_out;
      cap_err   = ~arith_flag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cmd_ready      <= 1'b1;
      arith_enable   <= 1'b0;
      alu_func_arith <= '0;
      arith_a        <= '0;
      arith_b        <= '0;
      cnt            <= '0;
    end else begin
      arith_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (guard_hit) begin
              state <= ST_HOLD;
            end else begin
              state          <= ST_ISSUE;
              arith_enable   <= 1'b1;
              alu_func_arith <= cmd_op;
              arith_a        <= cmd_a;
              arith_b        <= cmd_b;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= CNT_LOAD;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_rsp_hold #(.OUT_W(OUT_W)) u_rsp_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (cap_load),
    .load_data  (cap_data),
    .load_carry (cap_carry),
    .load_err   (cap_err),
    .rsp_ready  (rsp_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a one-stage registered model of the arithmetic unit.
module tb_alu_op_sequencer;

  localparam int unsigned IN_W      = 4;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned ARITH_LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [IN_W-1:0]  cmd_a = '0;
  logic [IN_W-1:0]  cmd_b = '0;
  logic [IN_W-1:0]  arith_a;
  logic [IN_W-1:0]  arith_b;
  logic             arith_enable;
  logic [1:0]       alu_func_arith;
  logic [OUT_W-1:0] arith_out = '0;
  logic             carry_out = 1'b0;
  logic             arith_flag = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [OUT_W-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_err;

  always #5 clk = ~clk;

  alu_op_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .ARITH_LAT(ARITH_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .arith_a        (arith_a),
    .arith_b        (arith_b),
    .arith_enable   (arith_enable),
    .alu_func_arith (alu_func_arith),
    .arith_out      (arith_out),
    .carry_out      (carry_out),
    .arith_flag     (arith_flag),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_carry      (rsp_carry),
    .rsp_err        (rsp_err)
  );

  // Unit model: one registered stage; carry is bit IN_W of the full result, divide-by-zero returns -1 unflagged.
  logic drop_flag = 1'b0;
  int   ma, mb, mr;
  always @(posedge clk) begin
    if (arith_enable) begin
      ma = int'($signed(arith_a));
      mb = int'($signed(arith_b));
      case (alu_func_arith)
        2'b00:   mr = ma + mb;
        2'b01:   mr = ma - mb;
        2'b10:   mr = ma * mb;
        default: mr = (mb == 0) ? -1 : ma / mb;
      endcase
      arith_out  <= mr[OUT_W-1:0];
      carry_out  <= mr[IN_W];
      arith_flag <= !drop_flag && !(alu_func_arith == 2'b11 && mb == 0);
    end
  end

  int cyc = 0, en_count = 0, last_en = 0, prev_en = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arith_enable) begin
      en_count <= en_count + 1;
      prev_en  <= last_en;
      last_en  <= cyc;
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         output int edges);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    edges = 1;
    while (!rsp_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic drain(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_valid_low"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
  endtask

  int edges, en0, i;

  initial begin
    rst = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_enable", 32'(arith_enable), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_arith_ab", 32'({arith_a, arith_b, alu_func_arith}), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // 1: add 3+4, step by step
    en0 = en_count;
    cmd_op = 2'b00; cmd_a = 4'd3; cmd_b = 4'd4; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("add_issue_en", 32'(arith_enable), 32'h1);
    chk("add_issue_fab", 32'({alu_func_arith, arith_a, arith_b}), 32'h034);
    chk("add_cmd_ready", 32'(cmd_ready), 32'h0);
    tick();
    chk("add_wait_en", 32'(arith_enable), 32'h0);
    chk("add_wait_valid", 32'(rsp_valid), 32'h0);
    tick();
    chk("add_valid", 32'(rsp_valid), 32'h1);
    chk("add_data", 32'(rsp_data), 32'h7);
    chk("add_carry_err", 32'({rsp_carry, rsp_err}), 32'h0);
    chk("add_en_pulses", 32'(en_count - en0), 32'h1);
    chk("add_hold_fab", 32'({alu_func_arith, arith_a, arith_b}), 32'h034);
    drain("add");

    // 2: sub and mul with sign extension
    run_cmd(2'b01, 4'd2, 4'd5, edges);
    chk("sub_lat", 32'(edges), 32'h3);
    chk("sub_data", 32'(rsp_data), 32'hFFFD);
    chk("sub_carry_err", 32'({rsp_carry, rsp_err}), 32'h2);
    drain("sub");
    run_cmd(2'b10, 4'hD, 4'd5, edges);
    chk("mul_lat", 32'(edges), 32'h3);
    chk("mul_data", 32'(rsp_data), 32'hFFF1);
    chk("mul_carry_err", 32'({rsp_carry, rsp_err}), 32'h2);
    drain("mul");

    // 3: backpressure with a competing command held upstream
    run_cmd(2'b00, 4'd5, 4'd6, edges);
    en0 = en_count;
    cmd_op = 2'b01; cmd_a = 4'd1; cmd_b = 4'd1; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_data", 32'({rsp_data, rsp_carry, rsp_err}), 32'({16'h000B, 2'b00}));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
    end
    chk("bp_no_issue", 32'(en_count - en0), 32'h0);
    cmd_valid = 1'b0;
    drain("bp");

    // 4: divide by zero
    en0 = en_count;
    run_cmd(2'b11, 4'd6, 4'd0, edges);
`ifdef ALU_DIV_ZERO_GUARD_EN
    chk("div0_lat", 32'(edges), 32'h1);
    chk("div0_data", 32'(rsp_data), 32'h0);
    chk("div0_carry_err", 32'({rsp_carry, rsp_err}), 32'h1);
    chk("div0_no_issue", 32'(en_count - en0), 32'h0);
`else
    chk("div0_lat", 32'(edges), 32'h3);
    chk("div0_data", 32'(rsp_data), 32'hFFFF);
    chk("div0_carry_err", 32'({rsp_carry, rsp_err}), 32'h3);
    chk("div0_issued", 32'(en_count - en0), 32'h1);
`endif
    drain("div0");

    // 5: reset during WAIT
    cmd_op = 2'b00; cmd_a = 4'd3; cmd_b = 4'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'h1);
    chk("mid_rst_outs", 32'({arith_enable, alu_func_arith, arith_a, arith_b, rsp_err, rsp_carry}), 32'h0);
    chk("mid_rst_data", 32'(rsp_data), 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    run_cmd(2'b00, 4'd1, 4'd1, edges);
    chk("post_rst_add", 32'({rsp_data, rsp_err}), 32'({16'h0002, 1'b0}));
    drain("post_rst");

    // 6: missing flag, then back-to-back issue interval
    drop_flag = 1'b1;
    run_cmd(2'b00, 4'd2, 4'd2, edges);
    chk("noflag_err", 32'({rsp_data, rsp_err}), 32'({16'h0004, 1'b1}));
    drop_flag = 1'b0;
    drain("noflag");
    cmd_op = 2'b00; cmd_a = 4'd1; cmd_b = 4'd2; cmd_valid = 1'b1; rsp_ready = 1'b1;
    en0 = en_count;
    for (i = 0; i < 10; i++) tick();
    cmd_valid = 1'b0;
    for (i = 0; i < 6; i++) tick();
    rsp_ready = 1'b0;
    chk("b2b_issues", 32'(en_count - en0), 32'h3);
    chk("b2b_interval", 32'(last_en - prev_en), 32'h4);
    chk("b2b_idle", 32'({cmd_ready, rsp_valid, rsp_data[3:0]}), 32'({1'b1, 1'b0, 4'h3}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
